// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit and its DataMem port.
package load_store_unit_pkg;

    localparam int N             = 32;   // data/address width
    localparam int MEM_CELL_SIZE = 8;    // bits per addressable cell (byte)
    localparam int DATA_MEM_SIZE = 256;  // DataMem size in bytes

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10,
        MEM_X = 2'b11
    } mem_size_t;

    // Size/alignment legality of an access (range is checked separately).
    function automatic logic access_illegal(input mem_size_t size, input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            MEM_B:   bad = 1'b0;
            MEM_H:   bad = offset[0];
            MEM_W:   bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering for a big-endian word memory: extracts and
// extends a loaded byte/half/word, and merges store data into a read word.
module lsu_lane_align
    import load_store_unit_pkg::*;
#(
    parameter int N = load_store_unit_pkg::N
) (
    input  mem_size_t      size_i,
    input  logic [1:0]     offset_i,
    input  logic           signed_i,
    input  logic [N-1:0]   load_word_i,
    input  logic [N-1:0]   base_word_i,
    input  logic [N-1:0]   wdata_i,
    output logic [N-1:0]   load_data_o,
    output logic [N-1:0]   merged_word_o
);

    localparam int B = MEM_CELL_SIZE;

    logic [4:0]   shamt;
    logic [N-1:0] mask;
    logic [N-1:0] field;

    // Lane k sits at bits [N-1-8k -: 8]; shifting right by (3-k) bytes
    // right-justifies it (a half at k in {0,2} shifts by (2-k) bytes).
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        shamt         = '0;
        mask          = '1;
        load_data_o   = '0;
        merged_word_o = '0;
        case (size_i)
            MEM_B: begin
                shamt = {~offset_i, 3'b000};
                mask  = N'({B{1'b1}});
            end
            MEM_H: begin
                shamt = {~offset_i[1], 4'b0000};
                mask  = N'({2*B{1'b1}});
            end
            default: begin
                shamt = '0;
                mask  = '1;
            end
        endcase

        field = (load_word_i >> shamt) & mask;
        case (size_i)
            MEM_B:   load_data_o = {{(N-B){signed_i & field[B-1]}}, field[B-1:0]};
            MEM_H:   load_data_o = {{(N-2*B){signed_i & field[2*B-1]}}, field[2*B-1:0]};
            default: load_data_o = field;
        endcase

        merged_word_o = (base_word_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns CPU byte/half/word requests into whole-word DataMem
// accesses, doing read-modify-write for sub-word stores.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int N         = load_store_unit_pkg::N,
    parameter int MEM_BYTES = DATA_MEM_SIZE
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [N-1:0]  req_addr,
    input  logic [N-1:0]  req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [N-1:0]  resp_rdata,
    output logic          resp_err,
    output logic          mem_readEn,
    output logic          mem_writeEn,
    output logic [N-1:0]  mem_address,
    output logic [N-1:0]  mem_datain,
    input  logic [N-1:0]  mem_dataout
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WR   = 3'd2;
    localparam logic [2:0] S_ERR  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]   state_q,  state_d;
    logic         write_q,  write_d;
    mem_size_t    size_q,   size_d;
    logic         signed_q, signed_d;
    logic [N-1:0] addr_q,   addr_d;
    logic [N-1:0] wdata_q,  wdata_d;
    logic [N-1:0] word_q,   word_d;
    logic [N-1:0] rdata_q,  rdata_d;
    logic         err_q,    err_d;

    mem_size_t    req_size_c;
    logic [N:0]   req_last_byte;
    logic         req_bad;
    logic [N-1:0] load_data;
    logic [N-1:0] merged_word;

    assign req_size_c    = mem_size_t'(req_size);
    // Last byte of the enclosing word, (addr & ~3) + 3, computed without wrap.
    assign req_last_byte = {1'b0, req_addr[N-1:2], 2'b11};
    assign req_bad       = access_illegal(req_size_c, req_addr[1:0])
                         | (req_last_byte >= (N+1)'(MEM_BYTES));

    lsu_lane_align #(.N(N)) u_align (
        .size_i        (size_q),
        .offset_i      (addr_q[1:0]),
        .signed_i      (signed_q),
        .load_word_i   (mem_dataout),
        .base_word_i   (word_q),
        .wdata_i       (wdata_q),
        .load_data_o   (load_data),
        .merged_word_o (merged_word)
    );

    // Next-state logic: request capture in IDLE, then the access sequence.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    size_d   = req_size_c;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (req_bad)
                        state_d = S_ERR;
                    else if (!req_write || req_size_c != MEM_W)
                        state_d = S_RD;
                    else
                        state_d = S_WR;
                end
            end
            S_RD: begin
                word_d = mem_dataout;
                if (write_q) begin
                    state_d = S_WR;
                end else begin
                    rdata_d = load_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end
            end
            S_WR: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = S_RESP;
            end
            S_ERR: begin
                rdata_d = '0;
                err_d   = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset abandons any op.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rstn) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            size_q   <= MEM_B;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            word_q   <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Outputs decoded from state; memory bus is zero whenever no access is made.
    always_comb begin
        req_ready   = (state_q == S_IDLE);
        resp_valid  = (state_q == S_RESP);
        mem_readEn  = (state_q == S_RD);
        mem_writeEn = (state_q == S_WR);
        resp_rdata  = resp_valid ? rdata_q : '0;
        resp_err    = resp_valid & err_q;
        mem_address = (mem_readEn | mem_writeEn) ? {addr_q[N-1:2], 2'b00} : '0;
        mem_datain  = mem_writeEn ? merged_word : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit with a word-wide DataMem
// responder and a byte-array reference model.
module tb_load_store_unit;

    localparam int MB = 256;
    localparam int NW = MB / 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_readEn;
    logic        mem_writeEn;
    logic [31:0] mem_address;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.N(32), .MEM_BYTES(MB)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_readEn (mem_readEn),
        .mem_writeEn(mem_writeEn),
        .mem_address(mem_address),
        .mem_datain (mem_datain),
        .mem_dataout(mem_dataout)
    );

    always #5 clk = ~clk;

    // DataMem responder: combinational word read, word write on posedge.
    logic [31:0] dmem [0:NW-1];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    assign mem_dataout = dmem[mem_address[7:2]];

    always @(posedge clk) begin
        if (pl_en) dmem[pl_idx] <= pl_val;
        else if (mem_writeEn) dmem[mem_address[7:2]] <= mem_datain;
    end

    // Reference model: plain byte array, byte a lives at big-endian lane a%4.
    logic [7:0] ref_mem [0:MB-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_err(input int size, input logic [31:0] addr);
        longint base;
        base = longint'(addr) - longint'(addr % 4);
        return (size == 3) || (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 0)
               || (base + 3 >= MB);
    endfunction

    function automatic logic [31:0] ref_word(input int base);
        logic [31:0] v = 0;
        for (int i = 0; i < 4; i++) v = (v << 8) | 32'(ref_mem[base + i]);
        return v;
    endfunction

    function automatic logic [31:0] ref_load(input int size, input bit sgn, input int addr);
        int len = 1 << size;
        logic [31:0] v = 0;
        for (int i = 0; i < len; i++) v = (v << 8) | 32'(ref_mem[addr + i]);
        if (sgn && len < 4 && v[8*len-1]) v = v | (32'hFFFF_FFFF << (8*len));
        return v;
    endfunction

    task automatic ref_store(input int size, input int addr, input logic [31:0] wdata);
        int len = 1 << size;
        for (int i = 0; i < len; i++) ref_mem[addr + i] = 8'(wdata >> (8 * (len - 1 - i)));
    endtask

    // Called at a negedge with the DUT idle; writes both memory and model.
    task automatic preload(input int widx, input logic [31:0] w);
        pl_en = 1'b1; pl_idx = 6'(widx); pl_val = w;
        @(negedge clk);
        pl_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_mem[4*widx + i] = 8'(w >> (24 - 8*i));
    endtask

    task automatic pulse_reset();
        req_valid = 1'b0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    logic [31:0] last_rdata;

    // One transaction, called and returning at a negedge with the DUT idle.
    task automatic txn(input string tag, input bit wr, input logic [1:0] size, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        bit e;
        logic [31:0] exp_rd, exp_ww;
        int exp_lat, exp_reads, exp_writes, exp_wcyc;
        int reads, writes, rcyc, wcyc, lat;
        logic [31:0] waddr, wdat, raddr;
        bit idle_bus_dirty, got_resp;
        logic [33:0] held;

        e          = ref_err(int'(size), addr);
        exp_rd     = (!e && !wr) ? ref_load(int'(size), sgn, int'(addr)) : 32'h0;
        exp_ww     = 32'h0;
        if (!e && wr) begin
            ref_store(int'(size), int'(addr), wdata);
            exp_ww = ref_word(int'(addr) - int'(addr % 4));
        end
        exp_lat    = (!e && wr && size != 2'd2) ? 3 : 2;
        exp_reads  = (!e && (!wr || size != 2'd2)) ? 1 : 0;
        exp_writes = (!e && wr) ? 1 : 0;
        exp_wcyc   = (size == 2'd2) ? 1 : 2;

        check({tag, "/req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; resp_ready = (hold == 0);
        @(posedge clk);

        reads = 0; writes = 0; rcyc = 0; wcyc = 0; lat = 0;
        waddr = 0; wdat = 0; raddr = 0; idle_bus_dirty = 0; got_resp = 0;
        for (int k = 1; k <= 8 && !got_resp; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // Scramble request inputs: the unit must use the latched copy.
                req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
                req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
            end
            if (mem_readEn)  begin reads++;  rcyc = k; raddr = mem_address; end
            if (mem_writeEn) begin writes++; wcyc = k; waddr = mem_address; wdat = mem_datain; end
            if (!mem_readEn && !mem_writeEn && (mem_address != 0 || mem_datain != 0))
                idle_bus_dirty = 1;
            if (resp_valid) begin lat = k; got_resp = 1; end
        end

        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        if (!got_resp) begin
            pulse_reset();
            return;
        end
        check({tag, "/rdata"}, resp_rdata, exp_rd);
        check({tag, "/err"}, 32'(resp_err), 32'(e));
        check({tag, "/reads"}, 32'(reads), 32'(exp_reads));
        check({tag, "/writes"}, 32'(writes), 32'(exp_writes));
        check({tag, "/bus_zero"}, 32'(idle_bus_dirty), 32'd0);
        if (exp_reads == 1) begin
            check({tag, "/rd_cycle"}, 32'(rcyc), 32'd1);
            check({tag, "/rd_addr"}, raddr, {addr[31:2], 2'b00});
        end
        if (exp_writes == 1) begin
            check({tag, "/wr_cycle"}, 32'(wcyc), 32'(exp_wcyc));
            check({tag, "/wr_addr"}, waddr, {addr[31:2], 2'b00});
            check({tag, "/wr_data"}, wdat, exp_ww);
        end
        last_rdata = resp_rdata;

        held = {resp_valid, resp_err, resp_rdata};
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, "/hold_stable"}, 32'({resp_valid, resp_err, resp_rdata} == held), 32'd1);
            check({tag, "/hold_no_access"}, 32'({mem_readEn, mem_writeEn}), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check({tag, "/back_to_idle"}, 32'({resp_valid, req_ready}), 32'b01);
        if (exp_writes == 1)
            check({tag, "/mem_word"}, dmem[addr[7:2]], exp_ww);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int wr_bad;
        logic [1:0] sz;
        logic [31:0] a;

        repeat (2) @(negedge clk);
        check("reset/req_ready", 32'(req_ready), 32'd1);
        check("reset/outs_zero", 32'({resp_valid, resp_err, mem_readEn, mem_writeEn}), 32'd0);
        check("reset/bus_zero", mem_address | mem_datain | resp_rdata, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        for (int w = 0; w < NW; w++) preload(w, (w == 4) ? 32'h8122F344 : $urandom);

        // Sign/zero extension of lanes in the preloaded word.
        txn("lb_s", 0, 2'd0, 1, 32'h10, 0, 0);  check("lb_s/const", last_rdata, 32'hFFFFFF81);
        txn("lbu",  0, 2'd0, 0, 32'h10, 0, 0);  check("lbu/const",  last_rdata, 32'h00000081);
        txn("lh_s", 0, 2'd1, 1, 32'h12, 0, 0);  check("lh_s/const", last_rdata, 32'hFFFFF344);
        txn("lhu",  0, 2'd1, 0, 32'h12, 0, 0);  check("lhu/const",  last_rdata, 32'h0000F344);
        txn("lw",   0, 2'd2, 0, 32'h10, 0, 0);  check("lw/const",   last_rdata, 32'h8122F344);

        // Read-modify-write byte store, then word store and read-back.
        txn("sb",    1, 2'd0, 0, 32'h11, 32'h000000AA, 0);
        check("sb/const", dmem[4], 32'h81AAF344);
        txn("lw_sb", 0, 2'd2, 0, 32'h10, 0, 0); check("lw_sb/const", last_rdata, 32'h81AAF344);
        txn("sw",    1, 2'd2, 0, 32'h14, 32'hDEADBEEF, 0);
        txn("lh_sw", 0, 2'd1, 1, 32'h16, 0, 0); check("lh_sw/const", last_rdata, 32'hFFFFBEEF);

        // Error cases and the last legal word.
        txn("err_lw_mis", 0, 2'd2, 0, 32'h12, 0, 0);
        txn("err_lh_mis", 0, 2'd1, 0, 32'h11, 0, 0);
        txn("err_size",   0, 2'd3, 0, 32'h10, 0, 0);
        txn("err_range",  0, 2'd2, 0, 32'(MB), 0, 0);
        txn("err_sw_rng", 1, 2'd2, 0, 32'(MB), 32'h12345678, 0);
        txn("lw_last",    0, 2'd2, 0, 32'(MB - 4), 0, 0);
        txn("sb_last",    1, 2'd0, 0, 32'(MB - 1), 32'h5A, 0);

        // Reset during the read phase of a half store abandons the write.
        preload(4, 32'h8122F344);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd1; req_signed = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0000BEEF; resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_mid/in_read", 32'(mem_readEn), 32'd1);
        rstn = 1'b0;
        wr_bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) rstn = 1'b1;
            if (mem_writeEn) wr_bad++;
        end
        check("rst_mid/no_write", 32'(wr_bad), 32'd0);
        check("rst_mid/word", dmem[4], 32'h8122F344);
        check("rst_mid/idle", 32'({req_ready, resp_valid}), 32'b10);

        // Backpressure on the response.
        txn("hold_lb", 0, 2'd0, 1, 32'h13, 0, 3);
        txn("hold_sh", 1, 2'd1, 0, 32'h12, 32'h00001234, 3);

        // Randomized traffic against the byte model.
        for (int t = 0; t < 250; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = 32'($urandom_range(0, MB + 7));
            if ($urandom_range(0, 9) < 8 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
            txn("rand", 1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(0, 2));
        end

        wr_bad = 0;
        for (int w = 0; w < NW; w++) if (dmem[w] !== ref_word(4*w)) wr_bad++;
        check("final/mem_image", 32'(wr_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
